alu_seq: RTL and testbench

- Parametrised, multi-cycle successor to the single-cycle datapath ALU in the multi-cycle processor.
- Adds EOR, an iterative shift-add multiply (MUL) and a restoring unsigned divide (UDIV) to the ADD/SUB/AND/ORR set.
- Uses a start/busy/done handshake so the control FSM can stall in its execute state.
- Result and NZCV flags are registered and held stable until the next accepted start.

---
 rtl/alu_pkg.sv | 31 +++
 rtl/alu_comb.sv | 39 +++
 rtl/alu_seq.sv | 169 ++++++++++++++++
 tb/tb_alu_seq.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the multi-cycle ALU: operation encodings, FSM states
// and NZCV flag bit positions.
package alu_pkg;

  typedef enum logic [2:0] {
    ALU_ADD  = 3'b000,
    ALU_SUB  = 3'b001,
    ALU_AND  = 3'b010,
    ALU_ORR  = 3'b011,
    ALU_EOR  = 3'b100,
    ALU_MUL  = 3'b101,
    ALU_UDIV = 3'b110,
    ALU_RSVD = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_e;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  function automatic logic is_multi_cycle(alu_op_e op);
    return (op == ALU_MUL) || (op == ALU_UDIV);
  endfunction

endpackage

// File: rtl/alu_comb.sv
// Single-cycle ADD/SUB/AND/ORR/EOR datapath with NZCV generation; any other
// opcode yields a zero result.
module alu_comb
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  alu_op_e          op,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags
);

  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   sum;

  // SUB is ADD of the inverted operand with a carry-in of one
  always_comb begin
    b_eff  = op[0] ? ~b : b;
    sum    = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, op[0]};
    result = '0;
    flags  = '0;
    unique case (op)
      ALU_ADD, ALU_SUB: begin
        result         = sum[WIDTH-1:0];
        flags[FLAG_C]  = sum[WIDTH];
        flags[FLAG_V]  = ~(a[WIDTH-1] ^ b_eff[WIDTH-1]) & (a[WIDTH-1] ^ sum[WIDTH-1]);
      end
      ALU_AND: result = a & b;
      ALU_ORR: result = a | b;
      ALU_EOR: result = a ^ b;
      default: result = '0;
    endcase
    flags[FLAG_N] = result[WIDTH-1];
    flags[FLAG_Z] = (result == '0);
  end

endmodule

// File: rtl/alu_seq.sv
// Multi-cycle ALU with start/busy/done handshake: single-cycle logic ops,
// iterative shift-add multiply and restoring unsigned divide.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       ALUControl,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Result,
  output logic [3:0]       ALUFlags,
  output logic             DivByZero
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  alu_op_e          op_q, op_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [3:0]       flags_q, flags_d;
  logic             div_zero_q, div_zero_d;

  alu_op_e          op_in;
  logic [WIDTH-1:0] comb_result;
  logic [3:0]       comb_flags;
  logic [WIDTH:0]   rem_shift;
  logic [WIDTH-1:0] trial_result;
  logic [3:0]       trial_flags;
  logic             unused_trial_flags;
  logic             fits;
  logic [WIDTH-1:0] mul_acc, div_quot, div_rem, fin_result;
  logic             fin_div_zero;

  assign op_in = alu_op_e'(ALUControl);

  alu_comb #(.WIDTH(WIDTH)) u_single (
    .a      (a),
    .b      (b),
    .op     (op_in),
    .result (comb_result),
    .flags  (comb_flags)
  );

  // Divide step: opa_q shifts the dividend out MSB-first while the quotient
  // bits shift in at the bottom; acc_q holds the partial remainder.
  assign rem_shift = {acc_q, opa_q[WIDTH-1]};

  alu_comb #(.WIDTH(WIDTH)) u_trial (
    .a      (rem_shift[WIDTH-1:0]),
    .b      (opb_q),
    .op     (ALU_SUB),
    .result (trial_result),
    .flags  (trial_flags)
  );

  assign unused_trial_flags = ^{trial_flags[FLAG_N], trial_flags[FLAG_Z], trial_flags[FLAG_V]};
  assign fits         = rem_shift[WIDTH] | trial_flags[FLAG_C];
  assign div_quot     = {opa_q[WIDTH-2:0], fits};
  assign div_rem      = fits ? trial_result : rem_shift[WIDTH-1:0];
  assign mul_acc      = acc_q + (opb_q[0] ? opa_q : '0);
  assign fin_div_zero = (op_q == ALU_UDIV) && (opb_q == '0);
  assign fin_result   = (op_q == ALU_MUL) ? mul_acc : (fin_div_zero ? '1 : div_quot);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = is_multi_cycle(op_in) ? CALC : DONE;
      CALC:    if (cnt_q == LAST_CNT) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q != IDLE);
    done = (state_q == DONE);
  end

  always_comb begin
    cnt_d      = cnt_q;
    op_d       = op_q;
    opa_d      = opa_q;
    opb_d      = opb_q;
    acc_d      = acc_q;
    result_d   = result_q;
    flags_d    = flags_q;
    div_zero_d = div_zero_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (is_multi_cycle(op_in)) begin
            op_d  = op_in;
            opa_d = a;
            opb_d = b;
            acc_d = '0;
            cnt_d = '0;
          end else begin
            result_d   = comb_result;
            flags_d    = comb_flags;
            div_zero_d = 1'b0;
          end
        end
      end
      CALC: begin
        cnt_d = cnt_q + 1'b1;
        if (op_q == ALU_MUL) begin
          acc_d = mul_acc;
          opa_d = opa_q << 1;
          opb_d = opb_q >> 1;
        end else begin
          acc_d = div_rem;
          opa_d = div_quot;
        end
        if (cnt_q == LAST_CNT) begin
          result_d   = fin_result;
          flags_d    = {fin_result[WIDTH-1], (fin_result == '0), 1'b0, fin_div_zero};
          div_zero_d = fin_div_zero;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q      <= '0;
      op_q       <= ALU_ADD;
      opa_q      <= '0;
      opb_q      <= '0;
      acc_q      <= '0;
      result_q   <= '0;
      flags_q    <= '0;
      div_zero_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      op_q       <= op_d;
      opa_q      <= opa_d;
      opb_q      <= opb_d;
      acc_q      <= acc_d;
      result_q   <= result_d;
      flags_q    <= flags_d;
      div_zero_q <= div_zero_d;
    end
  end

  assign Result    = result_q;
  assign ALUFlags  = flags_q;
  assign DivByZero = div_zero_q;

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: directed vectors, randomized ops against an
// arithmetic reference model, back-to-back starts and mid-operation reset.
module tb_alu_seq;

  localparam int W     = 32;
  localparam int LIMIT = 100;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          start;
  logic [W-1:0]  a, b;
  logic [2:0]    ALUControl;
  logic          busy, done;
  logic [W-1:0]  Result;
  logic [3:0]    ALUFlags;
  logic          DivByZero;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] va;
    logic [W-1:0] vb;
    logic [W-1:0] res;
    logic [3:0]   fl;
    logic         dz;
  } vec_t;

  alu_seq #(.WIDTH(W)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .a          (a),
    .b          (b),
    .ALUControl (ALUControl),
    .busy       (busy),
    .done       (done),
    .Result     (Result),
    .ALUFlags   (ALUFlags),
    .DivByZero  (DivByZero)
  );

  always #5 clk = ~clk;

  // Reference model written straight from the arithmetic meaning of each op
  function automatic void model(input logic [2:0] op, input logic [W-1:0] x, input logic [W-1:0] y,
                                output logic [W-1:0] r, output logic [3:0] f, output logic dz);
    logic [63:0] p;
    logic c, v;
    c = 1'b0; v = 1'b0; dz = 1'b0; p = '0;
    case (op)
      3'd0: begin
        p = {32'b0, x} + {32'b0, y};
        r = p[W-1:0]; c = p[W];
        v = (x[W-1] == y[W-1]) && (r[W-1] != x[W-1]);
      end
      3'd1: begin
        r = x - y; c = (x >= y);
        v = (x[W-1] != y[W-1]) && (r[W-1] != x[W-1]);
      end
      3'd2: r = x & y;
      3'd3: r = x | y;
      3'd4: r = x ^ y;
      3'd5: begin p = {32'b0, x} * {32'b0, y}; r = p[W-1:0]; end
      3'd6: begin
        if (y == 0) begin r = '1; v = 1'b1; dz = 1'b1; end
        else r = x / y;
      end
      default: r = '0;
    endcase
    f = {r[W-1], (r == 0), c, v};
  endfunction

  function automatic int exp_latency(input logic [2:0] op);
    return (op == 3'd5 || op == 3'd6) ? W + 1 : 1;
  endfunction

  // Issues one operation and reports latency (edges from the start edge to done)
  task automatic run_op(input logic [2:0] op_i, input logic [W-1:0] a_i, input logic [W-1:0] b_i,
                        output int lat, output int busy_cycles, output logic [W-1:0] res,
                        output logic [3:0] fl, output logic dz);
    @(negedge clk);
    ALUControl = op_i; a = a_i; b = b_i; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 1;
    busy_cycles = busy ? 1 : 0;
    while (done !== 1'b1 && lat < LIMIT) begin
      @(posedge clk); #1;
      lat++;
      if (busy) busy_cycles++;
    end
    res = Result; fl = ALUFlags; dz = DivByZero;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; start = 1'b0; a = '0; b = '0; ALUControl = '0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
    n_checks++; if (Result !== '0) begin n_fail++; $display("[TB] FAIL reset_result: got %h expected 0", Result); end
    n_checks++; if (ALUFlags !== 4'b0) begin n_fail++; $display("[TB] FAIL reset_flags: got %b expected 0000", ALUFlags); end
    n_checks++; if (DivByZero !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_divzero: got %b expected 0", DivByZero); end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_directed();
    vec_t vecs [$];
    int lat, bc;
    logic [W-1:0] res;
    logic [3:0] fl;
    logic dz;
    vecs.push_back('{3'd0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 4'b0110, 1'b0});
    vecs.push_back('{3'd1, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 4'b0011, 1'b0});
    vecs.push_back('{3'd4, 32'hF0F0_F0F0, 32'hFFFF_0000, 32'h0F0F_F0F0, 4'b0000, 1'b0});
    vecs.push_back('{3'd2, 32'hF0F0_F0F0, 32'h0F0F_0F0F, 32'h0000_0000, 4'b0100, 1'b0});
    vecs.push_back('{3'd3, 32'h8000_0000, 32'h0000_0001, 32'h8000_0001, 4'b1000, 1'b0});
    vecs.push_back('{3'd7, 32'h0000_007B, 32'h0000_01C8, 32'h0000_0000, 4'b0100, 1'b0});
    vecs.push_back('{3'd5, 32'h0001_2345, 32'h0000_0100, 32'h0123_4500, 4'b0000, 1'b0});
    vecs.push_back('{3'd5, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFE, 4'b1000, 1'b0});
    vecs.push_back('{3'd6, 32'd100,       32'd7,          32'd14,        4'b0000, 1'b0});
    vecs.push_back('{3'd6, 32'd5,         32'd0,          32'hFFFF_FFFF, 4'b1001, 1'b1});
    foreach (vecs[i]) begin
      run_op(vecs[i].op, vecs[i].va, vecs[i].vb, lat, bc, res, fl, dz);
      n_checks++; if (lat != exp_latency(vecs[i].op)) begin n_fail++; $display("[TB] FAIL dir%0d_latency: got %0d expected %0d", i, lat, exp_latency(vecs[i].op)); end
      n_checks++; if (bc != exp_latency(vecs[i].op)) begin n_fail++; $display("[TB] FAIL dir%0d_busy_cycles: got %0d expected %0d", i, bc, exp_latency(vecs[i].op)); end
      n_checks++; if (res !== vecs[i].res) begin n_fail++; $display("[TB] FAIL dir%0d_result: got %h expected %h", i, res, vecs[i].res); end
      n_checks++; if (fl !== vecs[i].fl) begin n_fail++; $display("[TB] FAIL dir%0d_flags: got %b expected %b", i, fl, vecs[i].fl); end
      n_checks++; if (dz !== vecs[i].dz) begin n_fail++; $display("[TB] FAIL dir%0d_divzero: got %b expected %b", i, dz, vecs[i].dz); end
    end
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (Result !== 32'hFFFF_FFFF) begin n_fail++; $display("[TB] FAIL hold_result: got %h expected ffffffff", Result); end
    n_checks++; if (DivByZero !== 1'b1) begin n_fail++; $display("[TB] FAIL hold_divzero: got %b expected 1", DivByZero); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("[TB] FAIL hold_done: got %b expected 0", done); end
  endtask

  task automatic test_random();
    int lat, bc;
    logic [2:0] op;
    logic [W-1:0] ra, rb, res, er;
    logic [3:0] fl, ef;
    logic dz, edz;
    for (int i = 0; i < 30; i++) begin
      op = 3'($urandom_range(0, 7));
      ra = $urandom;
      rb = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 20)) : $urandom;
      model(op, ra, rb, er, ef, edz);
      run_op(op, ra, rb, lat, bc, res, fl, dz);
      n_checks++; if (lat != exp_latency(op)) begin n_fail++; $display("[TB] FAIL rnd%0d_latency op=%0d: got %0d expected %0d", i, op, lat, exp_latency(op)); end
      n_checks++; if (res !== er) begin n_fail++; $display("[TB] FAIL rnd%0d_result op=%0d a=%h b=%h: got %h expected %h", i, op, ra, rb, res, er); end
      n_checks++; if (fl !== ef) begin n_fail++; $display("[TB] FAIL rnd%0d_flags op=%0d a=%h b=%h: got %b expected %b", i, op, ra, rb, fl, ef); end
      n_checks++; if (dz !== edz) begin n_fail++; $display("[TB] FAIL rnd%0d_divzero op=%0d: got %b expected %b", i, op, dz, edz); end
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] a1, b1, a2, b2, er1, er2, res1, res2;
    logic [3:0] ef;
    logic edz, busy_gap;
    int n, first_done, second_done;
    a1 = $urandom; b1 = $urandom; a2 = $urandom; b2 = $urandom;
    model(3'd5, a1, b1, er1, ef, edz);
    model(3'd0, a2, b2, er2, ef, edz);
    first_done = -1; second_done = -1; res1 = '0; res2 = '0; busy_gap = 1'bx;
    @(negedge clk);
    ALUControl = 3'd5; a = a1; b = b1; start = 1'b1;
    @(posedge clk); #1;
    ALUControl = 3'd0; a = a2; b = b2;
    n = 1;
    if (done === 1'b1) begin first_done = n; res1 = Result; end
    while (second_done < 0 && n < 80) begin
      @(posedge clk); #1;
      n++;
      if (n == W + 2) busy_gap = busy;
      if (done === 1'b1) begin
        if (first_done < 0) begin first_done = n; res1 = Result; end
        else begin second_done = n; res2 = Result; end
      end
    end
    start = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (first_done != W + 1) begin n_fail++; $display("[TB] FAIL b2b_first_done: got %0d expected %0d", first_done, W + 1); end
    n_checks++; if (res1 !== er1) begin n_fail++; $display("[TB] FAIL b2b_mul_result: got %h expected %h", res1, er1); end
    n_checks++; if (busy_gap !== 1'b0) begin n_fail++; $display("[TB] FAIL b2b_idle_gap_busy: got %b expected 0", busy_gap); end
    n_checks++; if (second_done != W + 3) begin n_fail++; $display("[TB] FAIL b2b_second_done: got %0d expected %0d", second_done, W + 3); end
    n_checks++; if (res2 !== er2) begin n_fail++; $display("[TB] FAIL b2b_add_result: got %h expected %h", res2, er2); end
  endtask

  task automatic test_reset_mid_op();
    int lat, bc, dones;
    logic [W-1:0] res;
    logic [3:0] fl;
    logic dz;
    run_op(3'd0, 32'h1234_5678, 32'h1, lat, bc, res, fl, dz);
    @(negedge clk);
    ALUControl = 3'd6; a = 32'd100; b = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL midrst_busy: got %b expected 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("[TB] FAIL midrst_done: got %b expected 0", done); end
    n_checks++; if (Result !== '0) begin n_fail++; $display("[TB] FAIL midrst_result: got %h expected 0", Result); end
    n_checks++; if (ALUFlags !== 4'b0) begin n_fail++; $display("[TB] FAIL midrst_flags: got %b expected 0000", ALUFlags); end
    n_checks++; if (DivByZero !== 1'b0) begin n_fail++; $display("[TB] FAIL midrst_divzero: got %b expected 0", DivByZero); end
    @(negedge clk);
    reset_n = 1'b1;
    dones = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done === 1'b1) dones++;
    end
    n_checks++; if (dones != 0) begin n_fail++; $display("[TB] FAIL midrst_stray_done: got %0d expected 0", dones); end
    run_op(3'd0, 32'd2, 32'd3, lat, bc, res, fl, dz);
    n_checks++; if (res !== 32'd5) begin n_fail++; $display("[TB] FAIL midrst_add_result: got %h expected 5", res); end
    n_checks++; if (lat != 1) begin n_fail++; $display("[TB] FAIL midrst_add_latency: got %0d expected 1", lat); end
    n_checks++; if (fl !== 4'b0000) begin n_fail++; $display("[TB] FAIL midrst_add_flags: got %b expected 0000", fl); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_reset_mid_op();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
